// File: rtl/pulse_peak_detector.sv
// Pulse peak detector: sits after the shaping filter, arms on threshold
// crossings, tracks each pulse's maximum and the timestamp of that maximum,
// and hands one amplitude/timestamp record per pulse to a one-entry output
// buffer with valid/ready handshaking. Over-long (piled-up) pulses are
// aborted without a record; records arriving while the buffer is full are
// dropped and counted.
//
// Ports:
//   clk           system clock, rising edge
//   reset         asynchronous active-low reset
//   filter_data   signed filtered sample, one per clk
//   out_ready     consumer accepts the record when high together with out_valid
//   out_valid     record available
//   peak_amp      signed maximum sample of the pulse
//   peak_ts       timestamp of the maximum sample
//   lost_count    records dropped on a full buffer (saturating)
//   pileup_count  pulses aborted for exceeding MAX_WIDTH (saturating)
//   busy          detector is inside a pulse or its dead time
module pulse_peak_detector #(
    parameter int unsigned          SIZE_ADC_DATA = 14,
    parameter int unsigned          FW            = SIZE_ADC_DATA * 2 + 3,
    parameter logic signed [FW-1:0] THRESHOLD     = FW'(100),
    parameter int unsigned          HOLDOFF       = 4,
    parameter int unsigned          MAX_WIDTH     = 64,
    parameter int unsigned          TS_WIDTH      = 32
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic signed [FW-1:0] filter_data,
    input  logic                 out_ready,
    output logic                 out_valid,
    output logic signed [FW-1:0] peak_amp,
    output logic [TS_WIDTH-1:0]  peak_ts,
    output logic [15:0]          lost_count,
    output logic [15:0]          pileup_count,
    output logic                 busy
);

    localparam int unsigned WW = 10;
    localparam int unsigned HW = 8;
    localparam int unsigned CW = 16;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ARMED,
        ST_ABORT,
        ST_DEAD
    } state_e;

    state_e                state_q, state_d;
    logic signed [FW-1:0]  x_q;
    logic [TS_WIDTH-1:0]   ts_cnt_q;
    logic [TS_WIDTH-1:0]   ts_q;
    logic signed [FW-1:0]  max_q, max_d;
    logic [TS_WIDTH-1:0]   max_ts_q, max_ts_d;
    logic [WW-1:0]         width_q, width_d;
    logic [HW-1:0]         hold_q, hold_d;
    logic                  emit_q, emit_d;
    logic signed [FW-1:0]  emit_amp_q;
    logic [TS_WIDTH-1:0]   emit_ts_q;
    logic                  pile_inc;
    logic                  out_valid_q, out_valid_d;
    logic signed [FW-1:0]  peak_amp_q, peak_amp_d;
    logic [TS_WIDTH-1:0]   peak_ts_q, peak_ts_d;
    logic [CW-1:0]         lost_q, lost_d;
    logic [CW-1:0]         pile_q, pile_d;
    logic                  busy_q;
    logic                  above;

    assign above = (x_q > THRESHOLD);

    // Pulse tracking state machine, evaluates the registered sample x_q
    always_comb begin
        state_d  = state_q;
        max_d    = max_q;
        max_ts_d = max_ts_q;
        width_d  = width_q;
        hold_d   = hold_q;
        emit_d   = 1'b0;
        pile_inc = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (above) begin
                    state_d  = ST_ARMED;
                    max_d    = x_q;
                    max_ts_d = ts_q;
                    width_d  = WW'(1);
                end
            end
            ST_ARMED: begin
                if (!above) begin
                    state_d = ST_DEAD;
                    hold_d  = HW'(HOLDOFF);
                    emit_d  = 1'b1;
                end else begin
                    // strict compare keeps the earliest sample of a flat top
                    if (x_q > max_q) begin
                        max_d    = x_q;
                        max_ts_d = ts_q;
                    end
                    if (width_q == WW'(MAX_WIDTH - 1)) begin
                        state_d  = ST_ABORT;
                        pile_inc = 1'b1;
                    end else begin
                        width_d = width_q + WW'(1);
                    end
                end
            end
            ST_ABORT: begin
                if (!above) begin
                    state_d = ST_DEAD;
                    hold_d  = HW'(HOLDOFF);
                end
            end
            ST_DEAD: begin
                // count down first; only then wait for the signal to be low
                if (hold_q != '0) begin
                    hold_d = hold_q - HW'(1);
                end else if (!above) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // One-entry output buffer and saturating counters
    always_comb begin
        out_valid_d = out_valid_q;
        peak_amp_d  = peak_amp_q;
        peak_ts_d   = peak_ts_q;
        lost_d      = lost_q;
        if (emit_q) begin
            // a drain in the same clk frees the slot for the new record
            if (!out_valid_q || out_ready) begin
                out_valid_d = 1'b1;
                peak_amp_d  = emit_amp_q;
                peak_ts_d   = emit_ts_q;
            end else if (lost_q != '1) begin
                lost_d = lost_q + CW'(1);
            end
        end else if (out_valid_q && out_ready) begin
            out_valid_d = 1'b0;
        end
        pile_d = (pile_inc && (pile_q != '1)) ? pile_q + CW'(1) : pile_q;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            x_q         <= '0;
            ts_cnt_q    <= '0;
            ts_q        <= '0;
            state_q     <= ST_IDLE;
            max_q       <= '0;
            max_ts_q    <= '0;
            width_q     <= '0;
            hold_q      <= '0;
            emit_q      <= 1'b0;
            emit_amp_q  <= '0;
            emit_ts_q   <= '0;
            out_valid_q <= 1'b0;
            peak_amp_q  <= '0;
            peak_ts_q   <= '0;
            lost_q      <= '0;
            pile_q      <= '0;
            busy_q      <= 1'b0;
        end else begin
            x_q         <= filter_data;
            ts_q        <= ts_cnt_q;
            ts_cnt_q    <= ts_cnt_q + TS_WIDTH'(1);
            state_q     <= state_d;
            max_q       <= max_d;
            max_ts_q    <= max_ts_d;
            width_q     <= width_d;
            hold_q      <= hold_d;
            emit_q      <= emit_d;
            if (emit_d) begin
                emit_amp_q <= max_q;
                emit_ts_q  <= max_ts_q;
            end
            out_valid_q <= out_valid_d;
            peak_amp_q  <= peak_amp_d;
            peak_ts_q   <= peak_ts_d;
            lost_q      <= lost_d;
            pile_q      <= pile_d;
            busy_q      <= (state_d != ST_IDLE);
        end
    end

    assign out_valid    = out_valid_q;
    assign peak_amp     = peak_amp_q;
    assign peak_ts      = peak_ts_q;
    assign lost_count   = lost_q;
    assign pileup_count = pile_q;
    assign busy         = busy_q;

endmodule

// File: tb/tb_pulse_peak_detector.sv
// Testbench for pulse_peak_detector: directed vector table, hand-written
// corner sequences, and a randomized run against a pulse-level reference model.
module tb_pulse_peak_detector;

    localparam int FW   = 31;
    localparam int TH   = 100;
    localparam int HOLD = 4;
    localparam int MW   = 64;
    localparam int NR   = 4000;

    logic                 clk;
    logic                 reset;
    logic signed [FW-1:0] filter_data;
    logic                 out_ready;
    logic                 out_valid;
    logic signed [FW-1:0] peak_amp;
    logic [31:0]          peak_ts;
    logic [15:0]          lost_count;
    logic [15:0]          pileup_count;
    logic                 busy;

    int total = 0;
    int bad   = 0;

    pulse_peak_detector #(
        .HOLDOFF  (HOLD),
        .MAX_WIDTH(MW),
        .TS_WIDTH (32)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .filter_data (filter_data),
        .out_ready   (out_ready),
        .out_valid   (out_valid),
        .peak_amp    (peak_amp),
        .peak_ts     (peak_ts),
        .lost_count  (lost_count),
        .pileup_count(pileup_count),
        .busy        (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    typedef struct {
        int d;
        bit rdy;
        bit ev;
        int amp;
        int ts;
        bit bsy;
    } vec_t;

    vec_t vt[15];

    int  s_arr[NR];
    bit  r_arr[NR];
    bit  busy_after[NR];
    bit  rec_v[NR+2];
    int  rec_a[NR+2];
    int  rec_t[NR+2];
    bit  pile_ev[NR+1];

    task automatic chk(input string nm, input logic signed [63:0] act, input logic signed [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got=%0d want=%0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // drive one sample, then observe just after the rising edge
    task automatic cyc(input int d, input bit r);
        filter_data = FW'(d);
        out_ready   = r;
        @(posedge clk);
        #1;
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_valid"}, out_valid, 0);
        chk({tag, "_amp"},   peak_amp, 0);
        chk({tag, "_ts"},    peak_ts, 0);
        chk({tag, "_lost"},  lost_count, 0);
        chk({tag, "_pile"},  pileup_count, 0);
        chk({tag, "_busy"},  busy, 0);
    endtask

    task automatic do_reset();
        reset = 1'b0;
        for (int k = 0; k < 5; k++) cyc(int'($urandom_range(0, 2000)) - 1000, 1'($urandom));
        chk_zero("reset");
        reset = 1'b1;
    endtask

    initial begin
        int nval;
        int saw;
        int idx, gap, len, prev, v;
        int i, L, e, k, mx, mt;
        int bv, bamp, bts, lost, pc;
        int fs[7];

        // single pulse: record 300 @ ts 4 for exactly one clk at obs 9
        vt[0]  = '{0,   1, 0, 0,   0, 0};
        vt[1]  = '{0,   1, 0, 0,   0, 0};
        vt[2]  = '{50,  1, 0, 0,   0, 0};
        vt[3]  = '{150, 1, 0, 0,   0, 0};
        vt[4]  = '{300, 1, 0, 0,   0, 1};
        vt[5]  = '{250, 1, 0, 0,   0, 1};
        vt[6]  = '{120, 1, 0, 0,   0, 1};
        vt[7]  = '{90,  1, 0, 0,   0, 1};
        vt[8]  = '{0,   1, 0, 0,   0, 1};
        vt[9]  = '{0,   1, 1, 300, 4, 1};
        vt[10] = '{0,   1, 0, 0,   0, 1};
        vt[11] = '{0,   1, 0, 0,   0, 1};
        vt[12] = '{0,   1, 0, 0,   0, 1};
        vt[13] = '{0,   1, 0, 0,   0, 0};
        vt[14] = '{0,   1, 0, 0,   0, 0};

        filter_data = '0;
        out_ready   = 1'b0;
        reset       = 1'b0;

        // reset state and quiet input
        do_reset();
        for (int c = 0; c < 10; c++) begin
            cyc(0, 1'b1);
            chk("quiet_valid", out_valid, 0);
            chk("quiet_busy", busy, 0);
        end

        // table-driven single pulse
        do_reset();
        for (int c = 0; c < 15; c++) begin
            cyc(vt[c].d, vt[c].rdy);
            chk($sformatf("tbl%0d_valid", c), out_valid, vt[c].ev);
            chk($sformatf("tbl%0d_busy", c), busy, vt[c].bsy);
            if (vt[c].ev) begin
                chk($sformatf("tbl%0d_amp", c), peak_amp, vt[c].amp);
                chk($sformatf("tbl%0d_ts", c), peak_ts, vt[c].ts);
            end
        end

        // flat top with a second bump inside the dead time
        do_reset();
        fs = '{0, 200, 300, 300, 50, 150, 0};
        nval = 0;
        for (int c = 0; c < 20; c++) begin
            cyc((c < 7) ? fs[c] : 0, 1'b1);
            if (out_valid) nval++;
            if (c == 6) begin
                chk("flat_valid", out_valid, 1);
                chk("flat_amp", peak_amp, 300);
                chk("flat_ts", peak_ts, 2);
            end
        end
        chk("flat_count", nval, 1);

        // backpressure: second record lost, first held then drained
        do_reset();
        for (int c = 0; c < 25; c++) begin
            cyc((c == 2) ? 300 : (c == 12) ? 500 : 0, 1'b0);
            if (c == 14) chk("bp_lost_before", lost_count, 0);
            if (c == 15) chk("bp_lost_after", lost_count, 1);
            if (c == 24) begin
                chk("bp_hold_valid", out_valid, 1);
                chk("bp_hold_amp", peak_amp, 300);
                chk("bp_hold_ts", peak_ts, 2);
                chk("bp_lost", lost_count, 1);
            end
        end
        saw = 0;
        nval = 0;
        for (int c = 25; c < 40; c++) begin
            cyc(0, 1'b1);
            if (out_valid) nval++;
            if (out_valid && peak_amp == 500) saw = 1;
        end
        chk("bp_drained", nval, 0);
        chk("bp_no500", saw, 0);
        chk("bp_lost_final", lost_count, 1);

        // pile-up abort, dead time, then a normal pulse
        do_reset();
        nval = 0;
        for (int c = 0; c < 120; c++) begin
            cyc((c >= 2 && c < 82) ? 400 : (c == 95) ? 150 : (c == 96) ? 250 : (c == 97) ? 200 : 0, 1'b1);
            if (c < 100 && out_valid) nval++;
            if (c == 65) chk("pile_before", pileup_count, 0);
            if (c == 66) chk("pile_after", pileup_count, 1);
            if (c == 87) chk("pile_busy_dead", busy, 1);
            if (c == 88) chk("pile_busy_idle", busy, 0);
            if (c == 100) begin
                chk("pile_next_valid", out_valid, 1);
                chk("pile_next_amp", peak_amp, 250);
                chk("pile_next_ts", peak_ts, 96);
            end
        end
        chk("pile_no_record", nval, 0);
        chk("pile_final", pileup_count, 1);

        // reset in the middle of a pulse
        do_reset();
        cyc(0, 1'b1);
        cyc(0, 1'b1);
        cyc(300, 1'b1);
        cyc(300, 1'b1);
        cyc(300, 1'b1);
        chk("mid_armed_busy", busy, 1);
        reset = 1'b0;
        #1;
        chk_zero("midrst");
        cyc(300, 1'b1);
        cyc(0, 1'b1);
        reset = 1'b1;
        for (int c = 0; c < 10; c++) begin
            cyc((c == 3) ? 180 : 0, 1'b1);
            if (c == 6) begin
                chk("mid_valid", out_valid, 1);
                chk("mid_amp", peak_amp, 180);
                chk("mid_ts", peak_ts, 3);
                chk("mid_lost", lost_count, 0);
            end
        end

        // randomized stream: baseline gaps, pulses of varied length, random ready
        idx = 0;
        while (idx < NR) begin
            gap = int'($urandom_range(0, 12));
            for (int g = 0; g < gap && idx < NR; g++) begin
                s_arr[idx] = int'($urandom_range(0, 150)) - 50;
                idx++;
            end
            len = ($urandom_range(0, 9) == 0) ? int'($urandom_range(55, 80)) : int'($urandom_range(1, 12));
            prev = 0;
            for (int p = 0; p < len && idx < NR; p++) begin
                v = (p > 0 && $urandom_range(0, 3) == 0) ? prev : int'($urandom_range(101, 700));
                s_arr[idx] = v;
                prev = v;
                idx++;
            end
        end
        for (int c = 0; c < NR; c++) r_arr[c] = ($urandom_range(0, 9) < 7);

        // reference: segment the stream into pulses and dead times
        i = 0;
        while (i < NR) begin
            if (s_arr[i] <= TH) begin
                i++;
                continue;
            end
            L = 0;
            while (i + L < NR && s_arr[i + L] > TH) L++;
            e = i + L;
            for (int q = i; q < e; q++) busy_after[q] = 1'b1;
            if (L >= MW) begin
                if (i + MW < NR) pile_ev[i + MW] = 1'b1;
            end else if (e < NR) begin
                mx = s_arr[i];
                mt = i;
                for (int q = i + 1; q < e; q++) begin
                    if (s_arr[q] > mx) begin
                        mx = s_arr[q];
                        mt = q;
                    end
                end
                rec_v[e + 2] = 1'b1;
                rec_a[e + 2] = mx;
                rec_t[e + 2] = mt;
            end
            if (e >= NR) break;
            busy_after[e] = 1'b1;
            k = e + 1;
            for (int h = 0; h < HOLD; h++) begin
                if (k < NR) busy_after[k] = 1'b1;
                k++;
            end
            while (k < NR && s_arr[k] > TH) begin
                busy_after[k] = 1'b1;
                k++;
            end
            i = k + 1;
        end

        do_reset();
        bv = 0; bamp = 0; bts = 0; lost = 0; pc = 0;
        for (int c = 0; c < NR; c++) begin
            cyc(s_arr[c], r_arr[c]);
            if (rec_v[c]) begin
                if (bv == 0 || r_arr[c]) begin
                    bv = 1;
                    bamp = rec_a[c];
                    bts = rec_t[c];
                end else if (lost < 65535) begin
                    lost++;
                end
            end else if (bv == 1 && r_arr[c]) begin
                bv = 0;
            end
            if (pile_ev[c]) pc++;
            chk("rnd_valid", out_valid, bv);
            chk("rnd_lost", lost_count, lost);
            chk("rnd_pile", pileup_count, pc);
            chk("rnd_busy", busy, (c == 0) ? 0 : int'(busy_after[c - 1]));
            if (bv == 1) begin
                chk("rnd_amp", peak_amp, bamp);
                chk("rnd_ts", peak_ts, bts);
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
